// File: rtl/rs_dec_pkg.sv
// Shared types and constants for the RS(255) erasure-flag front end.
// Holds codeword geometry, FSM states and the per-codeword report layout.
package rs_dec_pkg;

  localparam int N        = 255;
  localparam int ADDR_W   = 8;
  localparam int MAX_ERAS = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ZFILL
  } state_t;

  typedef struct packed {
    logic       bank;
    logic [7:0] count;
    logic       overflow;
    logic       len_err;
  } rpt_t;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] c,
    input logic       e
  );
    if (e && c != 8'hFF)
      return c + 8'd1;
    return c;
  endfunction

endpackage

// File: rtl/rs_erasure_flag_writer_if.sv
// Flag-writer bus: symbol stream in, flag RAM write port,
// codeword report out and bank release in.
interface rs_erasure_flag_writer_if #(
  parameter int ADDR_W = rs_dec_pkg::ADDR_W
);

  logic              in_valid;
  logic              in_ready;
  logic              in_sop;
  logic              in_eop;
  logic              in_erasure;
  logic              ram_wren;
  logic              ram_bank;
  logic [ADDR_W-1:0] ram_wraddress;
  logic              ram_data;
  logic              rpt_valid;
  logic              rpt_ready;
  logic              rpt_bank;
  logic [7:0]        rpt_count;
  logic              rpt_overflow;
  logic              rpt_len_err;
  logic              rel_valid;
  logic              rel_bank;

  modport master (
    input  in_valid,
    input  in_sop,
    input  in_eop,
    input  in_erasure,
    input  rpt_ready,
    input  rel_valid,
    input  rel_bank,
    output in_ready,
    output ram_wren,
    output ram_bank,
    output ram_wraddress,
    output ram_data,
    output rpt_valid,
    output rpt_bank,
    output rpt_count,
    output rpt_overflow,
    output rpt_len_err
  );

  modport slave (
    output in_valid,
    output in_sop,
    output in_eop,
    output in_erasure,
    output rpt_ready,
    output rel_valid,
    output rel_bank,
    input  in_ready,
    input  ram_wren,
    input  ram_bank,
    input  ram_wraddress,
    input  ram_data,
    input  rpt_valid,
    input  rpt_bank,
    input  rpt_count,
    input  rpt_overflow,
    input  rpt_len_err
  );

endinterface

// File: rtl/rs_bank_tracker.sv
// Ping-pong flag bank ownership: free bits per bank and the
// write pointer, with claim, close and release events.
module rs_bank_tracker (
  input  logic       clock,
  input  logic       reset,
  input  logic       claim,
  input  logic       close,
  input  logic       busy,
  input  logic       rel_valid,
  input  logic       rel_bank,
  output logic       wr_ptr,
  output logic [1:0] free_eff
);

  logic [1:0] free_q;
  logic [1:0] free_d;
  logic [1:0] rel_hit;
  logic       ptr_q;

  // The bank under fill cannot be released out from under us.
  always_comb begin
    rel_hit = 2'b00;
    if (rel_valid && !(busy && rel_bank == ptr_q))
      rel_hit[rel_bank] = 1'b1;
  end

  assign free_eff = free_q | rel_hit;

  always_comb begin
    free_d = free_eff;
    if (claim)
      free_d[ptr_q] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_q <= 2'b11;
      ptr_q  <= 1'b0;
    end else begin
      free_q <= free_d;
      if (close)
        ptr_q <= ~ptr_q;
    end
  end

  assign wr_ptr = ptr_q;

endmodule

// File: rtl/rs_erasure_flag_writer.sv
// Writes per-symbol erasure flags into ping-pong flag RAMs,
// zero-fills short frames and reports counts per codeword.
module rs_erasure_flag_writer #(
  parameter int N        = rs_dec_pkg::N,
  parameter int ADDR_W   = rs_dec_pkg::ADDR_W,
  parameter int MAX_ERAS = rs_dec_pkg::MAX_ERAS
) (
  input logic                      clock,
  input logic                      reset,
  rs_erasure_flag_writer_if.master bus
);

  import rs_dec_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic              lerr_q;
  logic              lerr_d;

  logic              wr_ptr;
  logic [1:0]        free_eff;
  logic              rdy;
  logic              accept;
  logic              claim;
  logic              close;
  logic              busy;

  logic              wren_d;
  logic [ADDR_W-1:0] addr_d;
  logic              data_d;
  logic              wren_q;
  logic              bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic              data_q;

  rpt_t              close_rpt;
  rpt_t              stage_q;
  logic              stage_vld_q;
  rpt_t              rpt_q;
  logic              rpt_vld_q;
  logic              slot_ok;
  logic              slot_load;

  assign busy      = (state_q != IDLE);
  assign slot_ok   = !rpt_vld_q || bus.rpt_ready;
  assign slot_load = stage_vld_q && slot_ok;
  assign accept    = bus.in_valid && rdy;

  rs_bank_tracker u_banks (
    .clock     (clock),
    .reset     (reset),
    .claim     (claim),
    .close     (close),
    .busy      (busy),
    .rel_valid (bus.rel_valid),
    .rel_bank  (bus.rel_bank),
    .wr_ptr    (wr_ptr),
    .free_eff  (free_eff)
  );

  always_comb begin
    rdy = 1'b0;
    unique case (state_q)
      IDLE:    rdy = free_eff[wr_ptr] && slot_ok;
      FILL:    rdy = 1'b1;
      ZFILL:   rdy = 1'b0;
      default: rdy = 1'b0;
    endcase
    if (reset)
      rdy = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lerr_d  = lerr_q;
    wren_d  = 1'b0;
    addr_d  = idx_q;
    data_d  = 1'b0;
    claim   = 1'b0;
    close   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && bus.in_sop) begin
          claim   = 1'b1;
          wren_d  = 1'b1;
          addr_d  = '0;
          data_d  = bus.in_erasure;
          cnt_d   = {7'd0, bus.in_erasure};
          lerr_d  = bus.in_eop;
          idx_d   = ONE;
          state_d = bus.in_eop ? ZFILL : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          wren_d = 1'b1;
          data_d = bus.in_erasure;
          cnt_d  = sat_inc(cnt_q, bus.in_erasure);
          if (idx_q == LAST) begin
            lerr_d  = lerr_q | bus.in_sop | !bus.in_eop;
            close   = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            lerr_d = lerr_q | bus.in_sop | bus.in_eop;
            idx_d  = idx_q + ONE;
            if (bus.in_eop)
              state_d = ZFILL;
          end
        end
      end
      ZFILL: begin
        // Clear the tail so last codeword's flags never leak through.
        wren_d = 1'b1;
        if (idx_q == LAST) begin
          close   = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    close_rpt.bank     = wr_ptr;
    close_rpt.count    = cnt_d;
    close_rpt.overflow = (cnt_d > 8'(MAX_ERAS));
    close_rpt.len_err  = lerr_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lerr_q  <= 1'b0;
      wren_q  <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lerr_q  <= lerr_d;
      wren_q  <= wren_d;
      bank_q  <= wr_ptr;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Staging delays the report one cycle past the last RAM write.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      rpt_q       <= '0;
      rpt_vld_q   <= 1'b0;
    end else begin
      if (close) begin
        stage_q     <= close_rpt;
        stage_vld_q <= 1'b1;
      end else if (slot_load) begin
        stage_vld_q <= 1'b0;
      end
      if (slot_load) begin
        rpt_q     <= stage_q;
        rpt_vld_q <= 1'b1;
      end else if (bus.rpt_ready) begin
        rpt_vld_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = rdy;
  assign bus.ram_wren      = wren_q;
  assign bus.ram_bank      = bank_q;
  assign bus.ram_wraddress = addr_q;
  assign bus.ram_data      = data_q;
  assign bus.rpt_valid     = rpt_vld_q;
  assign bus.rpt_bank      = rpt_q.bank;
  assign bus.rpt_count     = rpt_q.count;
  assign bus.rpt_overflow  = rpt_q.overflow;
  assign bus.rpt_len_err   = rpt_q.len_err;

endmodule

// File: tb/tb_rs_erasure_flag_writer.sv
// Directed bench for the erasure flag writer: full, overflow,
// short, bank stall, report stall and mid-frame reset cases.
module tb_rs_erasure_flag_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rs_erasure_flag_writer_if bus ();

  rs_erasure_flag_writer dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int   wa[$];
  logic wd[$];
  logic wb[$];
  logic wrv[$];

  logic       r_bank;
  logic [7:0] r_cnt;
  logic       r_ovf;
  logic       r_lerr;

  always @(negedge clk) begin
    if (bus.ram_wren === 1'b1) begin
      wa.push_back(int'(bus.ram_wraddress));
      wd.push_back(bus.ram_data);
      wb.push_back(bus.ram_bank);
      wrv.push_back(bus.rpt_valid);
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wb.delete();
    wrv.delete();
  endtask

  task automatic send_range(
    input int           from,
    input int           to,
    input logic [254:0] er,
    input int           eop_idx
  );
    for (int i = from; i <= to; i++) begin
      int   w;
      logic r;
      bus.in_valid   = 1'b1;
      bus.in_sop     = (i == 0);
      bus.in_eop     = (i == eop_idx);
      bus.in_erasure = er[i];
      w = 0;
      do begin
        @(negedge clk);
        r = bus.in_ready;
        @(posedge clk);
        #1;
        w++;
      end while (r !== 1'b1 && w < 400);
      if (r !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL beat_accept idx %0d: in_ready %b, want 1", i, r);
      end
    end
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_erasure = 1'b0;
  endtask

  task automatic get_report();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.rpt_valid !== 1'b1 && w < 600);
    if (bus.rpt_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rpt_wait: rpt_valid %b, want 1", bus.rpt_valid);
    end
    r_bank = bus.rpt_bank;
    r_cnt  = bus.rpt_count;
    r_ovf  = bus.rpt_overflow;
    r_lerr = bus.rpt_len_err;
    bus.rpt_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rpt_ready = 1'b0;
  endtask

  task automatic release_bank(input logic b);
    bus.rel_valid = 1'b1;
    bus.rel_bank  = b;
    @(posedge clk);
    #1;
    bus.rel_valid = 1'b0;
  endtask

  function automatic logic [22:0] out_vec();
    return {bus.ram_wren, bus.ram_bank, bus.ram_wraddress,
            bus.ram_data, bus.rpt_valid, bus.rpt_bank,
            bus.rpt_count, bus.rpt_overflow, bus.rpt_len_err};
  endfunction

  task automatic test_reset();
    logic [22:0] o;
    repeat (2) @(posedge clk);
    #1;
    o = out_vec();
    checks++;
    if (o !== 23'd0) begin
      errors++;
      $display("FAIL rst_outputs got %h want 0", o);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full();
    logic [254:0] er;
    int n;
    int bad;
    er = '0;
    er[0] = 1'b1;
    er[100] = 1'b1;
    er[254] = 1'b1;
    clear_log();
    send_range(0, 254, er, 254);
    get_report();
    n = wa.size();
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL full_nwrites got %0d want 255", n);
    end
    bad = 0;
    for (int i = 0; i < n && i < 255; i++)
      if (wa[i] != i || wb[i] !== 1'b0 || wd[i] !== er[i])
        bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_writes got %0d bad want 0", bad);
    end
    checks++;
    if (n < 1 || wrv[n-1] !== 1'b0) begin
      errors++;
      $display("FAIL full_rpt_early got n=%0d want rpt_valid 0 at last write", n);
    end
    checks++;
    if ({r_bank, r_cnt, r_ovf, r_lerr} !== {1'b0, 8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL full_rpt got b%b c%0d o%b l%b want b0 c3 o0 l0",
               r_bank, r_cnt, r_ovf, r_lerr);
    end
    release_bank(1'b0);
  endtask

  task automatic test_overflow();
    logic [254:0] er;
    er = '0;
    for (int i = 0; i < 17; i++)
      er[i] = 1'b1;
    send_range(0, 254, er, 254);
    get_report();
    checks++;
    if (r_cnt !== 8'd17) begin
      errors++;
      $display("FAIL ovf_count got %0d want 17", r_cnt);
    end
    checks++;
    if (r_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b want 1", r_ovf);
    end
    checks++;
    if (r_bank !== 1'b1 || r_lerr !== 1'b0) begin
      errors++;
      $display("FAIL ovf_bank got b%b l%b want b1 l0", r_bank, r_lerr);
    end
    release_bank(1'b1);
  endtask

  task automatic test_short();
    logic [254:0] er;
    int n;
    int bad;
    int z;
    er = '0;
    er[2] = 1'b1;
    er[9] = 1'b1;
    clear_log();
    send_range(0, 9, er, 9);
    z = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1)
        break;
      z++;
    end
    checks++;
    if (z != 245) begin
      errors++;
      $display("FAIL short_zfill_cycles got %0d want 245", z);
    end
    @(posedge clk);
    #1;
    get_report();
    n = wa.size();
    bad = 0;
    for (int i = 0; i < n && i < 255; i++)
      if (wa[i] != i || wb[i] !== 1'b0 || wd[i] !== (i < 10 ? er[i] : 1'b0))
        bad++;
    checks++;
    if (n != 255 || bad != 0) begin
      errors++;
      $display("FAIL short_writes got n=%0d bad=%0d want 255/0", n, bad);
    end
    checks++;
    if (r_lerr !== 1'b1) begin
      errors++;
      $display("FAIL short_len_err got %b want 1", r_lerr);
    end
    checks++;
    if (r_cnt !== 8'd2 || r_bank !== 1'b0 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL short_rpt got c%0d b%b o%b want c2 b0 o0",
               r_cnt, r_bank, r_ovf);
    end
  endtask

  task automatic test_bank_stall();
    logic [254:0] er;
    int hi;
    logic r;
    er = '0;
    for (int i = 100; i < 116; i++)
      er[i] = 1'b1;
    send_range(0, 254, er, 254);
    get_report();
    checks++;
    if ({r_bank, r_cnt, r_ovf} !== {1'b1, 8'd16, 1'b0}) begin
      errors++;
      $display("FAIL c16_rpt got b%b c%0d o%b want b1 c16 o0",
               r_bank, r_cnt, r_ovf);
    end
    clear_log();
    bus.in_valid   = 1'b1;
    bus.in_sop     = 1'b1;
    bus.in_erasure = 1'b1;
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0)
        hi++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL stall_bank got %0d ready cycles want 0", hi);
    end
    bus.rel_valid = 1'b1;
    bus.rel_bank  = 1'b0;
    @(negedge clk);
    r = bus.in_ready;
    @(posedge clk);
    #1;
    bus.rel_valid = 1'b0;
    checks++;
    if (r !== 1'b1) begin
      errors++;
      $display("FAIL rel_claim got in_ready %b want 1", r);
    end
    er = '0;
    er[0] = 1'b1;
    send_range(1, 254, er, 254);
    checks++;
    if (wa.size() < 1 || wa[0] != 0 || wb[0] !== 1'b0 || wd[0] !== 1'b1) begin
      errors++;
      $display("FAIL rel_first_write got n=%0d want bank0 addr0 data1",
               wa.size());
    end
  endtask

  task automatic test_rpt_stall();
    logic [254:0] er;
    int hi;
    logic r;
    release_bank(1'b1);
    clear_log();
    bus.in_valid   = 1'b1;
    bus.in_sop     = 1'b1;
    bus.in_erasure = 1'b0;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0)
        hi++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL stall_rpt got %0d ready cycles want 0", hi);
    end
    @(negedge clk);
    checks++;
    if ({bus.rpt_valid, bus.rpt_bank, bus.rpt_count} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL rpt_held got v%b b%b c%0d want v1 b0 c1",
               bus.rpt_valid, bus.rpt_bank, bus.rpt_count);
    end
    @(posedge clk);
    #1;
    bus.rpt_ready = 1'b1;
    @(negedge clk);
    r = bus.in_ready;
    @(posedge clk);
    #1;
    bus.rpt_ready = 1'b0;
    checks++;
    if (r !== 1'b1) begin
      errors++;
      $display("FAIL rpt_accept_ready got %b want 1", r);
    end
    er = '0;
    er[10] = 1'b1;
    er[20] = 1'b1;
    send_range(1, 49, er, -1);
    checks++;
    if (wa.size() < 1 || wa[0] != 0 || wb[0] !== 1'b1) begin
      errors++;
      $display("FAIL e_first_write got n=%0d want bank1 addr0", wa.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [254:0] er;
    logic [22:0] o;
    bus.in_valid   = 1'b1;
    bus.in_erasure = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    o = out_vec();
    checks++;
    if (o !== 23'd0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs got %h rdy %b want 0 0", o, bus.in_ready);
    end
    rst = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_erasure = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    clear_log();
    er = '0;
    er[5] = 1'b1;
    send_range(0, 254, er, 254);
    get_report();
    checks++;
    if ({r_bank, r_cnt, r_ovf, r_lerr} !== {1'b0, 8'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_rst_rpt got b%b c%0d o%b l%b want b0 c1 o0 l0",
               r_bank, r_cnt, r_ovf, r_lerr);
    end
    checks++;
    if (wa.size() != 255 || wb[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_writes got n=%0d want 255 in bank0", wa.size());
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_erasure = 1'b0;
    bus.rpt_ready  = 1'b0;
    bus.rel_valid  = 1'b0;
    bus.rel_bank   = 1'b0;
    test_reset();
    test_full();
    test_overflow();
    test_short();
    test_bank_stall();
    test_rpt_stall();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
